rounding_arbiter: RTL and testbench

- Shares one pipelined mantissa-rounding datapath between N_REQ requesters using round-robin arbitration and valid/ready handshakes.
- Each request carries a sign bit, a 2-bit rounding mode and a DATA_W-bit extended mantissa.
- Each response returns a 23-bit rounded mantissa, an overflow flag and the requester ID.
- Sits between the FP normalisation stages and the result packers of the FP units.

---
 rtl/rounding_arbiter_if.sv | 28 ++
 rtl/rounding_arbiter.sv | 119 +++++++++++
 tb/tb_rounding_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rounding_arbiter_if.sv
// Request/response bundle between FP normalisation requesters and the shared rounding datapath.
// The master side drives requests and consumes results; the slave side is the arbiter.
interface rounding_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = $clog2(N_REQ)
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        req_sign;
   logic [2*N_REQ-1:0]      req_mode;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [22:0]             out_mant;
   logic                    out_overfl;
   logic [ID_W-1:0]         out_id;

   modport master (
      output req_valid, req_sign, req_mode, req_data, out_ready,
      input  req_ready, out_valid, out_mant, out_overfl, out_id
   );

   modport slave (
      input  req_valid, req_sign, req_mode, req_data, out_ready,
      output req_ready, out_valid, out_mant, out_overfl, out_id
   );
endinterface

// File: rtl/rounding_arbiter.sv
// Round-robin arbiter in front of a two-stage mantissa-rounding pipeline.
// S1 captures the granted request; S2 holds the rounded result until downstream accepts it.
module rounding_arbiter #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = $clog2(N_REQ)
) (
   input  logic              clk,
   input  logic              rst,
   rounding_arbiter_if.slave bus
);
   localparam int unsigned MANT_W = 23;

   logic [DATA_W-1:0] data_arr [N_REQ];
   logic [1:0]        mode_arr [N_REQ];

   logic              s1_valid;
   logic              s1_sign;
   logic [1:0]        s1_mode;
   logic [DATA_W-1:0] s1_data;
   logic [ID_W-1:0]   s1_id;

   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   ptr_nxt;
   logic [ID_W-1:0]   grant;
   logic [ID_W-1:0]   cand;
   logic              grant_hit;
   logic              s2_free;
   logic              s1_free;
   logic              xfer;

   logic [MANT_W-1:0] m;
   logic [MANT_W-1:0] mant_nxt;
   logic              gb;
   logic              rb;
   logic              sb;
   logic              inc;
   logic              ovf_nxt;

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign data_arr[i] = bus.req_data[DATA_W*i +: DATA_W];
      assign mode_arr[i] = bus.req_mode[2*i +: 2];
   end

   assign s2_free = !bus.out_valid || bus.out_ready;
   assign s1_free = !s1_valid || s2_free;

   // First valid requester at or after ptr, wrapping around.
   always_comb begin : arb
      grant     = '0;
      grant_hit = 1'b0;
      cand      = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = ID_W'((32'(ptr) + i) % N_REQ);
         if (!grant_hit && bus.req_valid[cand]) begin
            grant     = cand;
            grant_hit = 1'b1;
         end
      end
   end

   assign xfer          = grant_hit && s1_free && !rst;
   assign bus.req_ready = xfer ? (N_REQ'(1) << grant) : '0;
   assign ptr_nxt       = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);

   assign m  = s1_data[DATA_W-1 -: MANT_W];
   assign gb = s1_data[DATA_W-MANT_W];
   assign rb = s1_data[DATA_W-MANT_W-1];
   assign sb = |s1_data[DATA_W-MANT_W-2:0];

   always_comb begin : round_inc
      inc = 1'b0;
      case (s1_mode)
         2'd0:    inc = rb & (gb | sb);
         2'd1:    inc = 1'b0;
         2'd2:    inc = ~s1_sign & (rb | sb);
         default: inc = s1_sign & (rb | sb);
      endcase
   end

   assign ovf_nxt  = (&m) & inc;
   assign mant_nxt = ovf_nxt ? '0 : m + MANT_W'(inc);

   always_ff @(posedge clk) begin : s1_ctrl
      if (rst) begin
         s1_valid <= 1'b0;
         ptr      <= '0;
      end else begin
         if (s1_free) s1_valid <= xfer;
         if (xfer)    ptr      <= ptr_nxt;
      end
   end

   // Payload needs no reset: it is only consumed while s1_valid is set.
   always_ff @(posedge clk) begin : s1_payload
      if (xfer) begin
         s1_sign <= bus.req_sign[grant];
         s1_mode <= mode_arr[grant];
         s1_data <= data_arr[grant];
         s1_id   <= grant;
      end
   end

   always_ff @(posedge clk) begin : s2_reg
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.out_mant   <= '0;
         bus.out_overfl <= 1'b0;
         bus.out_id     <= '0;
      end else if (s2_free) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            bus.out_mant   <= mant_nxt;
            bus.out_overfl <= ovf_nxt;
            bus.out_id     <= s1_id;
         end
      end
   end
endmodule

// File: tb/tb_rounding_arbiter.sv
// Bench for rounding_arbiter: directed scenarios plus random traffic against a
// queue-based reference of in-flight results and arithmetic rounding.
module tb_rounding_arbiter;
   localparam int unsigned N_REQ  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ID_W   = 2;
   localparam int unsigned PK_W   = N_REQ * DATA_W;
   localparam int unsigned MD_W   = 2 * N_REQ;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rounding_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();
   rounding_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          a;
      logic [22:0] mant;
      logic        ovf;
      int          id;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;
   int   ptr_m  = 0;

   logic [N_REQ-1:0]  t_valid;
   logic [N_REQ-1:0]  t_sign;
   logic [1:0]        t_mode [N_REQ];
   logic [DATA_W-1:0] t_data [N_REQ];
   logic              t_out_ready;

   logic [N_REQ-1:0]  exp_ready;
   logic              exp_valid;
   logic              exp_pop;
   logic              exp_xfer;
   int                exp_grant;

   // Rounding by integer arithmetic on the mantissa value and discarded remainder.
   function automatic exp_t round_ref(logic sign, logic [1:0] mode, logic [DATA_W-1:0] data, int id);
      exp_t            res;
      longint unsigned d    = 64'(data);
      longint unsigned sh   = 64'(DATA_W - 23);
      longint unsigned mv   = d >> sh;
      longint unsigned rem  = d - (mv << sh);
      longint unsigned half = 64'd1 << (sh - 1);
      bit              r    = rem >= half;
      bit              s    = (rem % half) != 0;
      bit              g    = (mv % 2) == 1;
      longint unsigned inc;
      longint unsigned sum;
      case (mode)
         2'd0:    inc = (r && (g || s)) ? 1 : 0;
         2'd1:    inc = 0;
         2'd2:    inc = (!sign && (r || s)) ? 1 : 0;
         default: inc = (sign && (r || s)) ? 1 : 0;
      endcase
      sum      = mv + inc;
      res.a    = 0;
      res.ovf  = (sum == (64'd1 << 23));
      res.mant = res.ovf ? 23'd0 : 23'(sum);
      res.id   = id;
      return res;
   endfunction

   task automatic apply();
      logic [PK_W-1:0] dp = '0;
      logic [MD_W-1:0] mp = '0;
      for (int i = 0; i < N_REQ; i++) begin
         dp |= PK_W'(t_data[i]) << (DATA_W * i);
         mp |= MD_W'(t_mode[i]) << (2 * i);
      end
      bus.req_valid = t_valid;
      bus.req_sign  = t_sign;
      bus.req_mode  = mp;
      bus.req_data  = dp;
      bus.out_ready = t_out_ready;
   endtask

   // At most two results in flight; head is visible from the second edge after acceptance.
   task automatic predict();
      int n = q.size();
      exp_valid = (n > 0) && (q[0].a < edge_n);
      exp_pop   = exp_valid && t_out_ready;
      exp_grant = -1;
      for (int k = 0; k < N_REQ; k++) begin
         int c = (ptr_m + k) % N_REQ;
         if (exp_grant < 0 && t_valid[ID_W'(c)]) exp_grant = c;
      end
      exp_xfer  = !rst && (exp_grant >= 0) && ((n - (exp_pop ? 1 : 0)) < 2);
      exp_ready = exp_xfer ? (N_REQ'(1) << exp_grant) : '0;
   endtask

   task automatic commit();
      exp_t e;
      if (exp_xfer)
         e = round_ref(t_sign[ID_W'(exp_grant)], t_mode[exp_grant], t_data[exp_grant], exp_grant);
      @(posedge clk);
      edge_n++;
      if (rst) begin
         q.delete();
         ptr_m = 0;
      end else begin
         if (exp_pop) void'(q.pop_front());
         if (exp_xfer) begin
            e.a   = edge_n;
            q.push_back(e);
            ptr_m = (exp_grant + 1) % N_REQ;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      t_valid     = '0;
      t_sign      = '0;
      t_out_ready = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
         t_mode[i] = 2'd0;
         t_data[i] = '0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) begin
         apply();
         @(negedge clk);
         predict();
         commit();
      end
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      idle_inputs();
      t_valid     = '1;
      t_out_ready = 1'b0;
      apply();
      @(negedge clk);
      predict();
      commit();
      @(negedge clk);
      predict();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++;
      if (bus.out_mant !== 23'd0) begin errors++; $display("FAIL reset_out_mant got=%h exp=0", bus.out_mant); end
      checks++;
      if (bus.out_overfl !== 1'b0) begin errors++; $display("FAIL reset_out_overfl got=%b exp=0", bus.out_overfl); end
      checks++;
      if (bus.out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id got=%0d exp=0", bus.out_id); end
      checks++;
      if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
      commit();
      rst = 1'b0;
   endtask

   task automatic test_basic_round();
      do_reset();
      t_data[0] = 32'h0000_0300;
      t_valid   = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         apply();
         @(negedge clk);
         predict();
         if (c == 0) begin
            checks++;
            if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready got=%b exp=0001", bus.req_ready); end
         end else if (c == 1) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency got=%b exp=0", bus.out_valid); end
         end else begin
            checks++;
            if ({bus.out_valid, bus.out_mant, bus.out_overfl, bus.out_id} !== {1'b1, 23'h000002, 1'b0, 2'd0}) begin
               errors++;
               $display("FAIL basic_result got v=%b m=%h o=%b id=%0d exp v=1 m=000002 o=0 id=0",
                        bus.out_valid, bus.out_mant, bus.out_overfl, bus.out_id);
            end
         end
         commit();
         t_valid = '0;
      end
   endtask

   task automatic test_modes();
      logic [1:0]  md [4] = '{2'd0, 2'd2, 2'd3, 2'd1};
      logic [22:0] em [4] = '{23'h7FFFFF, 23'h000000, 23'h7FFFFF, 23'h7FFFFF};
      logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      idle_inputs();
      t_data[1] = 32'hFFFF_FE40;
      for (int t = 0; t < 4; t++) begin
         t_mode[1] = md[t];
         t_valid   = 4'b0010;
         for (int c = 0; c < 3; c++) begin
            apply();
            @(negedge clk);
            predict();
            if (c == 2) begin
               checks++;
               if ({bus.out_valid, bus.out_mant, bus.out_overfl, bus.out_id} !== {1'b1, em[t], eo[t], 2'd1}) begin
                  errors++;
                  $display("FAIL mode%0d_result got v=%b m=%h o=%b id=%0d exp v=1 m=%h o=%b id=1",
                           md[t], bus.out_valid, bus.out_mant, bus.out_overfl, bus.out_id, em[t], eo[t]);
               end
            end
            commit();
            t_valid = '0;
         end
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         t_valid = (c < 8) ? 4'b1111 : 4'b0000;
         for (int i = 0; i < N_REQ; i++) t_data[i] = $urandom;
         apply();
         @(negedge clk);
         predict();
         if (c < 8) begin
            checks++;
            if (bus.req_ready !== (4'b0001 << (c % 4)))
               begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, 4'b0001 << (c % 4)); end
         end
         if (c >= 2) begin
            checks++;
            if ({bus.out_valid, bus.out_id} !== {1'b1, 2'((c - 2) % 4)})
               begin errors++; $display("FAIL rr_out c=%0d got v=%b id=%0d exp v=1 id=%0d", c, bus.out_valid, bus.out_id, (c - 2) % 4); end
            if (exp_valid) begin
               checks++;
               if ({bus.out_mant, bus.out_overfl} !== {q[0].mant, q[0].ovf})
                  begin errors++; $display("FAIL rr_data c=%0d got m=%h o=%b exp m=%h o=%b", c, bus.out_mant, bus.out_overfl, q[0].mant, q[0].ovf); end
            end
         end
         commit();
      end
   endtask

   task automatic test_backpressure();
      int          accepted = 0;
      logic [25:0] held;
      do_reset();
      t_valid     = 4'b1111;
      t_out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         for (int i = 0; i < N_REQ; i++) t_data[i] = $urandom;
         apply();
         @(negedge clk);
         predict();
         if (bus.req_ready != 0) accepted++;
         checks++;
         if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_ready); end
         if (c == 2) held = {bus.out_mant, bus.out_overfl, bus.out_id};
         if (c > 2) begin
            checks++;
            if ({bus.out_mant, bus.out_overfl, bus.out_id} !== held) begin errors++; $display("FAIL bp_hold c=%0d got=%h exp=%h", c, {bus.out_mant, bus.out_overfl, bus.out_id}, held); end
         end
         commit();
      end
      checks++;
      if (accepted !== 2) begin errors++; $display("FAIL bp_accepted got=%0d exp=2", accepted); end
      t_valid     = '0;
      t_out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         apply();
         @(negedge clk);
         predict();
         checks++;
         if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL bp_drain_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_valid); end
         if (exp_valid) begin
            checks++;
            if ({bus.out_mant, bus.out_overfl, bus.out_id} !== {q[0].mant, q[0].ovf, ID_W'(q[0].id)})
               begin errors++; $display("FAIL bp_drain_data c=%0d got m=%h o=%b id=%0d exp m=%h o=%b id=%0d", c, bus.out_mant, bus.out_overfl, bus.out_id, q[0].mant, q[0].ovf, q[0].id); end
         end
         if (c == 0 || c == 1) begin
            checks++;
            if (bus.out_id !== 2'(c)) begin errors++; $display("FAIL bp_order c=%0d got=%0d exp=%0d", c, bus.out_id, c); end
         end
         commit();
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_wrap();
      logic [N_REQ-1:0] vv [4] = '{4'b1000, 4'b0100, 4'b0110, 4'b0100};
      logic [N_REQ-1:0] rr [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0100};
      do_reset();
      for (int c = 0; c < 4; c++) begin
         t_valid = vv[c];
         apply();
         @(negedge clk);
         predict();
         checks++;
         if (bus.req_ready !== rr[c]) begin errors++; $display("FAIL wrap_grant c=%0d got=%b exp=%b", c, bus.req_ready, rr[c]); end
         commit();
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      t_valid     = 4'b1111;
      t_out_ready = 1'b0;
      repeat (3) begin
         apply();
         @(negedge clk);
         predict();
         commit();
      end
      rst = 1'b1;
      apply();
      @(negedge clk);
      predict();
      checks++;
      if ({bus.out_valid, bus.req_ready} !== {1'b1, 4'b0000}) begin errors++; $display("FAIL midrst_full got v=%b r=%b exp v=1 r=0000", bus.out_valid, bus.req_ready); end
      commit();
      @(negedge clk);
      predict();
      checks++;
      if ({bus.out_valid, bus.req_ready} !== {1'b0, 4'b0000}) begin errors++; $display("FAIL midrst_clear got v=%b r=%b exp v=0 r=0000", bus.out_valid, bus.req_ready); end
      commit();
      rst         = 1'b0;
      t_valid     = 4'b1010;
      t_out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         apply();
         @(negedge clk);
         predict();
         if (c == 0) begin
            checks++;
            if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL midrst_first_grant got=%b exp=0010", bus.req_ready); end
         end
         checks++;
         if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL midrst_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_valid); end
         commit();
         t_valid = '0;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         if (c < 580) begin
            t_valid     = N_REQ'($urandom);
            t_out_ready = ($urandom_range(9) < 7);
            for (int i = 0; i < N_REQ; i++) begin
               t_data[i] = $urandom;
               if ($urandom_range(3) == 0) t_data[i][DATA_W-1 -: 23] = '1;
               t_mode[i] = 2'($urandom);
               t_sign[i] = 1'($urandom);
            end
         end else begin
            t_valid     = '0;
            t_out_ready = 1'b1;
         end
         apply();
         @(negedge clk);
         predict();
         checks++;
         if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_ready); end
         checks++;
         if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_valid); end
         if (exp_valid) begin
            checks++;
            if ({bus.out_mant, bus.out_overfl, bus.out_id} !== {q[0].mant, q[0].ovf, ID_W'(q[0].id)})
               begin errors++; $display("FAIL rand_data c=%0d got m=%h o=%b id=%0d exp m=%h o=%b id=%0d", c, bus.out_mant, bus.out_overfl, bus.out_id, q[0].mant, q[0].ovf, q[0].id); end
         end
         commit();
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain got=%b exp=0", bus.out_valid); end
   endtask

   initial begin
      idle_inputs();
      apply();
      test_reset();
      test_basic_round();
      test_modes();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
